// File: rtl/systolic_pq_pkg.sv
// Shared types and constants for the systolic priority queue.
//   entry_w()  : entry width from key and value widths (key in MSBs, value in LSBs)
//   EntryW     : entry width used by the token struct and the datapath
//   SENTINEL   : empty-slot marker, all ones; sorts after every legal entry
//   tok_op_e   : token operation (OpNop / OpIns / OpExt)
//   tok_t      : token travelling down the cell chain
package systolic_pq_pkg;

  localparam int unsigned PqKw = 8;
  localparam int unsigned PqVw = 4;

  function automatic int unsigned entry_w(input int unsigned kw, input int unsigned vw);
    return kw + vw;
  endfunction

  localparam int unsigned EntryW = entry_w(PqKw, PqVw);

  localparam logic [EntryW-1:0] SENTINEL = '1;

  typedef enum logic [1:0] {
    OpNop = 2'd0,
    OpIns = 2'd1,
    OpExt = 2'd2
  } tok_op_e;

  typedef struct packed {
    tok_op_e           op;
    logic [EntryW-1:0] data;
  } tok_t;

  localparam tok_t TokNop = '{op: OpNop, data: SENTINEL};

endpackage

// File: rtl/systolic_pq_cell.sv
// One cell of the systolic priority queue: a sorted lo/hi pair plus the
// outgoing token register.
//   clk_i, rst_i : clock, synchronous active-high reset
//   tok_i        : token arriving this cycle (from the previous cell or the handshake)
//   nxt_lo_i     : lo of the next cell (SENTINEL for the last cell)
//   lo_o, hi_o   : stored pair, lo_o <= hi_o
//   tok_o        : token forwarded to the next cell (always NOP when IsLast)
module systolic_pq_cell
  import systolic_pq_pkg::*;
#(
  parameter bit IsLast = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tok_t              tok_i,
  input  logic [EntryW-1:0] nxt_lo_i,
  output logic [EntryW-1:0] lo_o,
  output logic [EntryW-1:0] hi_o,
  output tok_t              tok_o
);

  logic [EntryW-1:0] lo_q, lo_d, hi_q, hi_d;
  tok_t              tok_q, tok_d;
  logic [EntryW-1:0] s_min, s_med, s_max;

  systolic_pq_sort3 #(
    .W (EntryW)
  ) u_sort3 (
    .a_i   (lo_q),
    .b_i   (hi_q),
    .c_i   (tok_i.data),
    .min_o (s_min),
    .med_o (s_med),
    .max_o (s_max)
  );

  always_comb begin
    lo_d  = lo_q;
    hi_d  = hi_q;
    tok_d = TokNop;
    unique case (tok_i.op)
      OpIns: begin
        lo_d = s_min;
        hi_d = s_med;
        // A SENTINEL overflow carries no information; stop the token here.
        if (!IsLast && s_max != SENTINEL) tok_d = '{op: OpIns, data: s_max};
      end
      OpExt: begin
        lo_d = hi_q;
        hi_d = nxt_lo_i;
        if (!IsLast) tok_d = '{op: OpExt, data: SENTINEL};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lo_q  <= SENTINEL;
      hi_q  <= SENTINEL;
      tok_q <= TokNop;
    end else begin
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      tok_q <= tok_d;
    end
  end

  assign lo_o  = lo_q;
  assign hi_o  = hi_q;
  assign tok_o = tok_q;

endmodule

// File: rtl/systolic_pq_sort3.sv
// Three-way unsigned sorter.
//   a_i, b_i, c_i : entries to sort
//   min_o, med_o, max_o : the same entries in ascending order
module systolic_pq_sort3 #(
  parameter int unsigned W = 12
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] min_o,
  output logic [W-1:0] med_o,
  output logic [W-1:0] max_o
);

  logic [W-1:0] ab_lo, ab_hi;

  always_comb begin
    ab_lo = (a_i < b_i) ? a_i : b_i;
    ab_hi = (a_i < b_i) ? b_i : a_i;
    if (c_i < ab_lo) begin
      min_o = c_i;
      med_o = ab_lo;
      max_o = ab_hi;
    end else if (c_i < ab_hi) begin
      min_o = ab_lo;
      med_o = c_i;
      max_o = ab_hi;
    end else begin
      min_o = ab_lo;
      med_o = ab_hi;
      max_o = c_i;
    end
  end

endmodule

// File: rtl/systolic_pq.sv
// Systolic priority queue, capacity 2*DEPTH entries of {key, value}.
// Cell 0 always holds the minimum in lo; inserts and extracts ride down the
// chain one cell per cycle, and a one-cycle cool-down after every accept keeps
// consecutive tokens two cells apart so no cell sees a neighbour mid-update.
//   clk, rst            : clock, synchronous active-high reset
//   ins_valid/ins_data  : insert request / entry; accepted on ins_valid & ins_ready
//   ext_valid           : extract-min request; accepted on ext_valid & ext_ready
//   out_valid/out_data  : one-cycle pulse with the extracted minimum
//   count, empty, full  : occupancy
//   err                 : only with SYSTOLIC_PQ_CHECK_EN; sticky ordering / illegal-insert flag
module systolic_pq
  import systolic_pq_pkg::*;
#(
  parameter int unsigned KW    = PqKw,
  parameter int unsigned VW    = PqVw,
  parameter int unsigned DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ins_valid,
  input  logic [KW+VW-1:0]                  ins_data,
  output logic                              ins_ready,
  input  logic                              ext_valid,
  output logic                              ext_ready,
  output logic                              out_valid,
  output logic [KW+VW-1:0]                  out_data,
  output logic [$clog2(2*DEPTH+1)-1:0]      count,
  output logic                              empty,
  output logic                              full
`ifdef SYSTOLIC_PQ_CHECK_EN
  ,
  output logic                              err
`endif
);

  localparam int unsigned CW = $clog2(2*DEPTH+1);
  localparam logic [CW-1:0] Cap = CW'(2*DEPTH);

  logic [EntryW-1:0] lo     [DEPTH];
  logic [EntryW-1:0] nxt_lo [DEPTH];
  tok_t              tok_chain [DEPTH+1];

  logic              ins_acc, ext_acc;
  logic              cool_q, cool_d;
  logic [CW-1:0]     count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic [EntryW-1:0] out_data_q, out_data_d;

  // Handshake: extract has priority and both are blocked while cooling down.
  always_comb begin
    ext_ready = !rst && (count_q != '0) && !cool_q;
    ins_ready = !rst && (count_q != Cap) && !cool_q && !(ext_valid && ext_ready);
    ext_acc   = ext_valid && ext_ready;
    ins_acc   = ins_valid && ins_ready;
  end

  always_comb begin
    tok_chain[0] = TokNop;
    if (ext_acc)      tok_chain[0] = '{op: OpExt, data: SENTINEL};
    else if (ins_acc) tok_chain[0] = '{op: OpIns, data: ins_data};
  end

`ifdef SYSTOLIC_PQ_CHECK_EN
  logic [EntryW-1:0] hi [DEPTH];
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    if (i == DEPTH - 1) begin : g_tail
      assign nxt_lo[i] = SENTINEL;
    end else begin : g_mid
      assign nxt_lo[i] = lo[i+1];
    end

    systolic_pq_cell #(
      .IsLast (i == DEPTH - 1)
    ) u_cell (
      .clk_i    (clk),
      .rst_i    (rst),
      .tok_i    (tok_chain[i]),
      .nxt_lo_i (nxt_lo[i]),
      .lo_o     (lo[i]),
`ifdef SYSTOLIC_PQ_CHECK_EN
      .hi_o     (hi[i]),
`else
      .hi_o     (),
`endif
      .tok_o    (tok_chain[i+1])
    );
  end

  always_comb begin
    cool_d      = ins_acc || ext_acc;
    count_d     = count_q;
    if (ins_acc) count_d = count_q + 1'b1;
    if (ext_acc) count_d = count_q - 1'b1;
    out_valid_d = ext_acc;
    out_data_d  = ext_acc ? lo[0] : out_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cool_q      <= 1'b0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cool_q      <= cool_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == Cap);

`ifdef SYSTOLIC_PQ_CHECK_EN
  logic err_q, err_d, viol;

  // Ordering is only guaranteed for a cell once no token is touching it or
  // its right neighbour; tok_chain[DEPTH] is always NOP.
  always_comb begin
    viol = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tok_chain[i].op == OpNop && tok_chain[i+1].op == OpNop) begin
        if (lo[i] > hi[i] || hi[i] > nxt_lo[i]) viol = 1'b1;
      end
    end
    err_d = err_q || viol || (ins_acc && ins_data == SENTINEL);
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_systolic_pq.sv
// Self-checking bench for systolic_pq: a directed vector table, hand-written
// corner sequences and a random run, all checked against a queue-based model.
module tb_systolic_pq;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CAP   = 2 * DEPTH;
  localparam int unsigned CW    = $clog2(2*DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ins_valid = 1'b0;
  logic [11:0]   ins_data  = '0;
  logic          ins_ready;
  logic          ext_valid = 1'b0;
  logic          ext_ready;
  logic          out_valid;
  logic [11:0]   out_data;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
`ifdef SYSTOLIC_PQ_CHECK_EN
  logic          err;
`endif

  systolic_pq #(
    .KW    (8),
    .VW    (4),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ins_valid (ins_valid),
    .ins_data  (ins_data),
    .ins_ready (ins_ready),
    .ext_valid (ext_valid),
    .ext_ready (ext_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (count),
    .empty     (empty),
    .full      (full)
`ifdef SYSTOLIC_PQ_CHECK_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: unordered bag of entries plus the cool-down flag.
  logic [11:0] mq[$];
  bit          cool_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check readies against the model, clock, check outputs.
  task automatic step(input bit iv, input logic [11:0] id, input bit ev);
    bit eir, eer, ia, ea;
    logic [11:0] eo;
    int mi;
    eo = '0;
    ins_valid = iv; ins_data = id; ext_valid = ev;
    #1;
    eer = (mq.size() != 0) && !cool_m;
    eir = (mq.size() != CAP) && !cool_m && !(ev && eer);
    chk("ins_ready", 32'(ins_ready), 32'(eir));
    chk("ext_ready", 32'(ext_ready), 32'(eer));
    ea = ev && eer;
    ia = iv && eir;
    if (ea) begin
      mi = 0;
      for (int k = 1; k < mq.size(); k++) if (mq[k] < mq[mi]) mi = k;
      eo = mq[mi];
      mq.delete(mi);
    end
    if (ia) mq.push_back(id);
    cool_m = ea || ia;
    @(posedge clk); #1;
    chk("out_valid", 32'(out_valid), 32'(ea));
    if (ea) chk("out_data", 32'(out_data), 32'(eo));
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full",  32'(full),  32'(mq.size() == CAP));
  endtask

  task automatic idle();
    step(1'b0, 12'h000, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; ins_valid = 1'b0; ext_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ins_ready", 32'(ins_ready), 32'd0);
    chk("rst_ext_ready", 32'(ext_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("post_rst_ins_ready", 32'(ins_ready), 32'd1);
    chk("post_rst_ext_ready", 32'(ext_ready), 32'd0);
`ifdef SYSTOLIC_PQ_CHECK_EN
    chk("rst_err", 32'(err), 32'd0);
`endif
    mq.delete();
    cool_m = 1'b0;
  endtask

  typedef struct {
    bit          iv;
    logic [11:0] id;
    bit          ev;
    bit          ir;
    bit          er;
    bit          ov;
    logic [11:0] od;
    int          cnt;
  } vec_t;

  vec_t tv[13];

  initial begin
    // Insert 030, 010, 020 two cycles apart, then extract three times.
    tv[0]  = '{1'b1, 12'h030, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1};
    tv[1]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1};
    tv[2]  = '{1'b1, 12'h010, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 2};
    tv[3]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2};
    tv[4]  = '{1'b1, 12'h020, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 3};
    tv[5]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 3};
    tv[6]  = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1, 12'h010, 2};
    tv[7]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2};
    tv[8]  = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1, 12'h020, 1};
    tv[9]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1};
    tv[10] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1, 12'h030, 0};
    tv[11] = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 0};
    tv[12] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 0};

    do_reset();

    for (int v = 0; v < 13; v++) begin
      ins_valid = tv[v].iv; ins_data = tv[v].id; ext_valid = tv[v].ev;
      #1;
      chk($sformatf("tv%0d_ins_ready", v), 32'(ins_ready), 32'(tv[v].ir));
      chk($sformatf("tv%0d_ext_ready", v), 32'(ext_ready), 32'(tv[v].er));
      @(posedge clk); #1;
      chk($sformatf("tv%0d_out_valid", v), 32'(out_valid), 32'(tv[v].ov));
      if (tv[v].ov) chk($sformatf("tv%0d_out_data", v), 32'(out_data), 32'(tv[v].od));
      chk($sformatf("tv%0d_count", v), 32'(count), 32'(tv[v].cnt));
      chk($sformatf("tv%0d_empty", v), 32'(empty), 32'(tv[v].cnt == 0));
    end
    ins_valid = 1'b0; ext_valid = 1'b0;
    cool_m = 1'b0;

    // Fill with descending keys, probe the full boundary, then drain.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 12'(12'h080 - 12'h010 * k), 1'b0);
      idle();
    end
    chk("fill_full", 32'(full), 32'd1);
    step(1'b1, 12'h005, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 12'h000, 1'b1);
      chk("drain_asc", 32'(out_data), 32'(12'h010 + 12'h010 * k));
      idle();
    end

    // Simultaneous insert and extract at count==1: extract wins.
    step(1'b1, 12'h077, 1'b0);
    idle();
    step(1'b1, 12'h066, 1'b1);
    idle();
    step(1'b1, 12'h066, 1'b0);
    idle();
    step(1'b0, 12'h000, 1'b1);
    idle();

    // Duplicates.
    step(1'b1, 12'h220, 1'b0); idle();
    step(1'b1, 12'h220, 1'b0); idle();
    step(1'b1, 12'h110, 1'b0); idle();
    repeat (3) begin step(1'b0, 12'h000, 1'b1); idle(); end

    // Interleaved insert / extract every other cycle.
    repeat (3) begin
      step(1'b1, 12'h050, 1'b0); idle();
      step(1'b0, 12'h000, 1'b1); idle();
      step(1'b1, 12'h040, 1'b0); idle();
    end
    while (mq.size() != 0) begin step(1'b0, 12'h000, 1'b1); idle(); end

    // Random traffic.
    for (int r = 0; r < 400; r++) begin
      step(1'($urandom_range(0, 1)), 12'($urandom_range(0, 12'hFFE)),
           ($urandom_range(0, 2) == 0));
    end
    while (mq.size() != 0) begin step(1'b0, 12'h000, 1'b1); idle(); end
`ifdef SYSTOLIC_PQ_CHECK_EN
    chk("err_clean", 32'(err), 32'd0);
`endif

    // Reset with tokens in flight at count==5.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 12'(12'h0A0 - 12'h011 * k), 1'b0);
      if (k != 4) idle();
    end
    rst = 1'b1; ins_valid = 1'b0; ext_valid = 1'b1;
    @(posedge clk); #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_ext_ready", 32'(ext_ready), 32'd0);
    ext_valid = 1'b0;
    do_reset();
    step(1'b1, 12'h123, 1'b0); idle();
    step(1'b0, 12'h000, 1'b1); idle();

`ifdef SYSTOLIC_PQ_CHECK_EN
    step(1'b1, 12'hFFF, 1'b0);
    chk("err_sentinel_ins", 32'(err), 32'd1);
    idle();
    chk("err_sticky", 32'(err), 32'd1);
    do_reset();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
